// File: rtl/bcd_a_binario.sv
// Four-digit packed BCD to 14-bit binary converter using reverse double-dabble.
// One shift/correct iteration per clock; result appears 14 clocks after acceptance.
module bcd_a_binario (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd_in,
    output logic [13:0] bin_out,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'd13;

    state_t      state_q, state_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] bin_q, bin_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] bin_out_q, bin_out_d;
    logic        error_q, error_d;

    logic        digits_ok;
    logic        accept;
    logic        last_iter;
    logic [15:0] bcd_shift;
    logic [15:0] bcd_adj;
    logic [13:0] bin_shift;

    function automatic logic [3:0] fix_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    always_comb begin
        digits_ok = (bcd_in[15:12] <= 4'd9) && (bcd_in[11:8] <= 4'd9) &&
                    (bcd_in[7:4]   <= 4'd9) && (bcd_in[3:0]  <= 4'd9);
        accept    = (state_q == S_IDLE) && start && digits_ok;
        last_iter = (cnt_q == LAST_ITER);
    end

    // One iteration: shift {bcd, bin} right, then pull every digit >= 8 down by 3.
    always_comb begin
        bcd_shift = {1'b0, bcd_q[15:1]};
        bin_shift = {bcd_q[0], bin_q[13:1]};
        bcd_adj   = '0;
        for (int i = 0; i < 4; i++) begin
            bcd_adj[4*i +: 4] = fix_digit(bcd_shift[4*i +: 4]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        error_d   = (state_q == S_IDLE) && start && !digits_ok;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bcd_d = bcd_in;
                    bin_d = '0;
                    cnt_d = '0;
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = bin_shift;
                if (last_iter) begin
                    bin_out_d = bin_shift;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            error_q   <= 1'b0;
        end else begin
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            error_q   <= error_d;
        end
    end

    // Output logic; error is only ever raised in the cycle after an IDLE
    // rejection, so it cannot coincide with valid (DONE).
    always_comb begin
        valid   = (state_q == S_DONE);
        busy    = (state_q != S_IDLE);
        error   = error_q;
        bin_out = bin_out_q;
    end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Bench for bcd_a_binario: vector table, directed corner sequences and
// random round trips against a decimal-arithmetic reference model.
module tb_bcd_a_binario;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        valid;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;
    int exp_hold = 0;

    typedef struct {
        logic [15:0] bcd;
        int          bin;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    bcd_a_binario dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .valid   (valid),
        .busy    (busy),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference model: decimal encode/decode with plain arithmetic.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit model_ok(input logic [15:0] b);
        return (b[15:12] < 10) && (b[11:8] < 10) && (b[7:4] < 10) && (b[3:0] < 10);
    endfunction

    function automatic int model_val(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Issue one request; inject_at >= 0 drives a competing start during SHIFT.
    task automatic run_req(input logic [15:0] bcd, input int exp_bin, input bit exp_err,
                           input string name, input int inject_at);
        int n;
        bit err_seen;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        if (exp_err) begin
            check({name, "_error"}, int'(error), 1);
            check({name, "_err_busy"}, int'(busy), 0);
            check({name, "_err_valid"}, int'(valid), 0);
            check({name, "_err_hold"}, int'(bin_out), exp_hold);
            @(negedge clk);
            check({name, "_err_pulse_end"}, int'(error), 0);
            check({name, "_err_no_valid"}, int'(valid), 0);
        end else begin
            check({name, "_busy"}, int'(busy), 1);
            n = 0;
            err_seen = 1'b0;
            while (!valid && n < 30) begin
                if (n == inject_at) begin
                    start  = 1'b1;
                    bcd_in = 16'h0777;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
                if (error) err_seen = 1'b1;
            end
            start = 1'b0;
            check({name, "_latency"}, n, 14);
            check({name, "_bin"}, int'(bin_out), exp_bin);
            check({name, "_no_error"}, int'(err_seen), 0);
            exp_hold = exp_bin;
            @(negedge clk);
            check({name, "_valid_end"}, int'(valid), 0);
            check({name, "_idle"}, int'(busy), 0);
        end
    endtask

    initial begin
        int n;
        int v;
        int bad_valid;
        logic [15:0] r;

        vecs[0] = '{16'h9999, 9999, 1'b0};
        vecs[1] = '{16'h0000, 0,    1'b0};
        vecs[2] = '{16'h1234, 1234, 1'b0};
        vecs[3] = '{16'h12A4, 0,    1'b1};
        vecs[4] = '{16'h0001, 1,    1'b0};
        vecs[5] = '{16'h8000, 8000, 1'b0};
        vecs[6] = '{16'hF000, 0,    1'b1};
        vecs[7] = '{16'h0989, 989,  1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_bin", int'(bin_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);

        // First start on the first edge with rst low.
        rst    = 1'b0;
        start  = 1'b1;
        bcd_in = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        check("first_accept_busy", int'(busy), 1);
        n = 0;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("first_latency", n, 14);
        check("first_bin", int'(bin_out), 7);
        exp_hold = 7;

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].bcd, vecs[i].bin, vecs[i].err, $sformatf("vec%0d", i), -1);
        end

        // Competing start during SHIFT is ignored.
        run_req(16'h0042, 42, 1'b0, "ignore_start", 5);
        run_req(16'h0777, 777, 1'b0, "after_ignore", -1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0123;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_bin", int'(bin_out), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_error", int'(error), 0);
        rst = 1'b0;
        exp_hold = 0;
        bad_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid || busy) bad_valid++;
        end
        check("midrst_aborted", bad_valid, 0);
        run_req(16'h0500, 500, 1'b0, "after_rst", -1);

        // Start held high: re-accepted one cycle after valid.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0321;
        @(negedge clk);
        n = 0;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("held_latency", n, 14);
        check("held_bin", int'(bin_out), 321);
        @(negedge clk);
        check("held_idle_gap", int'(busy), 0);
        @(negedge clk);
        check("held_reaccept", int'(busy), 1);
        start = 1'b0;
        n = 0;
        while (!valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("held2_latency", n, 14);
        check("held2_bin", int'(bin_out), 321);
        exp_hold = 321;
        @(negedge clk);

        // Random round trips.
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 9999);
            run_req(to_bcd(v), v, 1'b0, $sformatf("rt%0d", i), -1);
        end

        // Random raw words, some with invalid digits.
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom);
            run_req(r, model_ok(r) ? model_val(r) : 0, !model_ok(r), $sformatf("raw%0d", i), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
